// File: rtl/fa_response_checker.sv
// Full-adder response checker: compares observed sum/carry against a reference,
// tracks per-run mismatch count, {a,b,cin} coverage and the first failing vector.
module fa_response_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             s,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic             fail_valid,
  output logic [4:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam bit         COV_REQ  = (NUM_VECTORS >= 8);

  state_t           state, state_nxt;
  logic [7:0]       vec_cnt, vec_cnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [7:0]       cov_nxt;
  logic             fail_valid_nxt;
  logic [4:0]       fail_vec_nxt;
  logic             pass_nxt;
  logic             exp_s, exp_c;
  logic             sample_ok;

  // Reference model; an unknown on any bit leaves sample_ok low so it counts as a mismatch
  always_comb begin
    exp_s     = a ^ b ^ cin;
    exp_c     = (a & b) | (a & cin) | (b & cin);
    sample_ok = 1'b0;
    if ((s == exp_s) && (c == exp_c))
      sample_ok = 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    vec_cnt_nxt    = vec_cnt;
    err_nxt        = err_count;
    cov_nxt        = coverage;
    fail_valid_nxt = fail_valid;
    fail_vec_nxt   = fail_vec;
    pass_nxt       = pass;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = RUN;
          vec_cnt_nxt    = '0;
          err_nxt        = '0;
          cov_nxt        = '0;
          fail_valid_nxt = 1'b0;
          fail_vec_nxt   = '0;
          pass_nxt       = 1'b0;
        end
      end
      RUN: begin
        if (in_valid) begin
          vec_cnt_nxt             = vec_cnt + 8'd1;
          cov_nxt[{a, b, cin}]    = 1'b1;
          if (!sample_ok) begin
            if (err_count != '1)
              err_nxt = err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid_nxt = 1'b1;
              fail_vec_nxt   = {a, b, cin, s, c};
            end
          end
          // Verdict is formed from the post-update values so the last sample counts
          if (vec_cnt == LAST_IDX) begin
            state_nxt = DONE;
            pass_nxt  = (err_nxt == '0) && (!COV_REQ || (cov_nxt == 8'hFF));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec_cnt    <= '0;
      err_count  <= '0;
      coverage   <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      vec_cnt    <= vec_cnt_nxt;
      err_count  <= err_nxt;
      coverage   <= cov_nxt;
      fail_valid <= fail_valid_nxt;
      fail_vec   <= fail_vec_nxt;
      pass       <= pass_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: one instance with 8 vectors per run,
// a second with 20 vectors for err_count saturation.
module tb_fa_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start20;
  logic       in_valid;
  logic       a, b, cin, s, c;

  logic       busy8, done8, pass8, fv8;
  logic [3:0] err8;
  logic [7:0] cov8;
  logic [4:0] fvec8;

  logic       busy20, done20, pass20, fv20;
  logic [3:0] err20;
  logic [7:0] cov20;
  logic [4:0] fvec20;

  int checks = 0;
  int errors = 0;

  // Hand-derived truth tables indexed by {a,b,cin}
  logic [7:0] sum_tbl   = 8'b1001_0110;
  logic [7:0] carry_tbl = 8'b1110_1000;

  always #5 clk = ~clk;

  fa_response_checker #(.NUM_VECTORS(8), .ERR_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .s(s), .c(c),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
    .coverage(cov8), .fail_valid(fv8), .fail_vec(fvec8)
  );

  fa_response_checker #(.NUM_VECTORS(20), .ERR_W(4)) dut20 (
    .clk(clk), .rst(rst), .start(start20), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .s(s), .c(c),
    .busy(busy20), .done(done20), .pass(pass20), .err_count(err20),
    .coverage(cov20), .fail_valid(fv20), .fail_vec(fvec20)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus; flip inverts {s,c} relative to the correct response
  task automatic applyStimulus(input logic st8, input logic st20, input logic iv,
                               input logic [2:0] code, input logic [1:0] flip);
    @(negedge clk);
    start8   = st8;
    start20  = st20;
    in_valid = iv;
    {a, b, cin} = code;
    s = sum_tbl[code] ^ flip[1];
    c = carry_tbl[code] ^ flip[0];
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
  endtask

  initial begin
    rst = 1'b1; start8 = 0; start20 = 0; in_valid = 0;
    a = 0; b = 0; cin = 0; s = 0; c = 0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    checkOutput("rst_pass", pass8, 0);
    checkOutput("rst_err", err8, 0);
    checkOutput("rst_cov", cov8, 0);
    checkOutput("rst_fv", fv8, 0);
    checkOutput("rst_fvec", fvec8, 0);
    rst = 1'b0;

    // Exhaustive correct run
    applyStimulus(1, 0, 0, 3'b000, 2'b00);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 3'(i), 2'b00);
      if (i == 7) begin
        checkOutput("ex_busy_mid", busy8, 1);
        checkOutput("ex_done_mid", done8, 0);
      end
    end
    idleCycle();
    checkOutput("ex_done", done8, 1);
    checkOutput("ex_busy", busy8, 0);
    checkOutput("ex_pass", pass8, 1);
    checkOutput("ex_err", err8, 0);
    checkOutput("ex_cov", cov8, 8'hFF);
    checkOutput("ex_fv", fv8, 0);

    // Single fault on code 110 reporting s=1,c=1
    applyStimulus(1, 0, 0, 3'b000, 2'b00);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 1, 3'(i), (i == 6) ? 2'b10 : 2'b00);
    idleCycle();
    checkOutput("sf_done", done8, 1);
    checkOutput("sf_err", err8, 1);
    checkOutput("sf_fvec", fvec8, 5'b11011);
    checkOutput("sf_fv", fv8, 1);
    checkOutput("sf_pass", pass8, 0);

    // Incomplete coverage: 000 replaces 111
    applyStimulus(1, 0, 0, 3'b000, 2'b00);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 1, (i == 7) ? 3'b000 : 3'(i), 2'b00);
    idleCycle();
    checkOutput("ic_done", done8, 1);
    checkOutput("ic_cov", cov8, 8'h7F);
    checkOutput("ic_pass", pass8, 0);
    checkOutput("ic_err", err8, 0);

    // Samples in DONE are ignored
    applyStimulus(0, 0, 1, 3'b111, 2'b11);
    idleCycle();
    checkOutput("dn_ign_err", err8, 0);
    checkOutput("dn_ign_cov", cov8, 8'h7F);
    checkOutput("dn_ign_done", done8, 1);

    // Start with a valid sample in DONE: start wins, sample dropped
    applyStimulus(1, 0, 1, 3'b101, 2'b11);
    idleCycle();
    checkOutput("sv_busy", busy8, 1);
    checkOutput("sv_cov", cov8, 0);
    checkOutput("sv_err", err8, 0);
    checkOutput("sv_fv", fv8, 0);

    // Gapped samples, two faults, a start pulse mid-run
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 3'(i), (i == 2) ? 2'b10 : ((i == 5) ? 2'b01 : 2'b00));
      applyStimulus((i == 3), 0, 0, 3'b000, 2'b00);
      if (i == 3) begin
        checkOutput("gp_busy_mid", busy8, 1);
        checkOutput("gp_cov_mid", cov8, 8'h0F);
        checkOutput("gp_err_mid", err8, 1);
      end
      if (i == 6)
        checkOutput("gp_done_early", done8, 0);
    end
    checkOutput("gp_done", done8, 1);
    checkOutput("gp_err", err8, 2);
    checkOutput("gp_cov", cov8, 8'hFF);
    checkOutput("gp_fvec", fvec8, 5'b01000);
    checkOutput("gp_pass", pass8, 0);

    // Async reset mid-run after three samples
    applyStimulus(1, 0, 0, 3'b000, 2'b00);
    applyStimulus(0, 0, 1, 3'b000, 2'b00);
    applyStimulus(0, 0, 1, 3'b001, 2'b01);
    applyStimulus(0, 0, 1, 3'b010, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("ar_err_pre", err8, 1);
    checkOutput("ar_fvec_pre", fvec8, 5'b00111);
    #1 rst = 1'b1;
    #1;
    checkOutput("ar_busy", busy8, 0);
    checkOutput("ar_err", err8, 0);
    checkOutput("ar_cov", cov8, 0);
    checkOutput("ar_fv", fv8, 0);
    checkOutput("ar_fvec", fvec8, 0);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 1, 3'b011, 2'b11);
    applyStimulus(0, 0, 1, 3'b100, 2'b11);
    idleCycle();
    checkOutput("ar_ign_busy", busy8, 0);
    checkOutput("ar_ign_done", done8, 0);
    checkOutput("ar_ign_err", err8, 0);
    checkOutput("ar_ign_cov", cov8, 0);

    // Saturation on the 20-vector instance
    applyStimulus(0, 1, 0, 3'b000, 2'b00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 3'(i % 8), 2'b11);
      if (i == 19) begin
        checkOutput("sat_busy_mid", busy20, 1);
        checkOutput("sat_done_mid", done20, 0);
        checkOutput("sat_err_mid", err20, 15);
      end
    end
    idleCycle();
    checkOutput("sat_done", done20, 1);
    checkOutput("sat_err", err20, 15);
    checkOutput("sat_fv", fv20, 1);
    checkOutput("sat_fvec", fvec20, 5'b00011);
    checkOutput("sat_pass", pass20, 0);
    checkOutput("sat_cov", cov20, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fa_response_checker.md
FA_RESPONSE_CHECKER -- requirements
Module: fa_response_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 8, SHALL set the number of samples checked per run (legal range 1..255).
REQ-002 Parameter ERR_W, default 4, SHALL set the err_count width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be the run-start strobe, sampled on clk.
REQ-006 in_valid  input  1  SHALL qualify the a/b/cin/s/c sample on the current cycle.
REQ-007 a, b, cin  input  1 each  SHALL be the full-adder stimulus bits.
REQ-008 s, c  input  1 each  SHALL be the observed full-adder sum and carry.
REQ-009 busy  output  1  SHALL be high while in RUN.
REQ-010 done  output  1  SHALL be high while in DONE.
REQ-011 pass  output  1  SHALL be the run verdict, valid while done=1.
REQ-012 err_count  output  ERR_W  SHALL be the mismatch count for the current/last run.
REQ-013 coverage  output  8  SHALL hold the bitmap of {a,b,cin} codes seen this run (bit index = {a,b,cin}).
REQ-014 fail_valid  output  1  SHALL be high once the first mismatch of the run is captured.
REQ-015 fail_vec  output  5  SHALL hold {a,b,cin,s,c} of the first mismatch.

Function
REQ-016 Expected values: exp_s = a^b^cin; exp_c = majority(a,b,cin).
REQ-017 A sample SHALL mismatch when s!=exp_s or c!=exp_c.
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE->RUN on start=1; on that edge, clear err_count, coverage, fail_valid, fail_vec and the internal vector counter.
REQ-020 RUN: each cycle with in_valid=1 is one sample; increment the vector counter and set coverage[{a,b,cin}].
REQ-021 RUN: on a mismatching sample, err_count += 1, saturating at 2^ERR_W-1.
REQ-022 RUN: on the first mismatch of the run, load fail_vec and set fail_valid; later mismatches do not change either.
REQ-023 RUN->DONE on the edge that accepts sample number NUM_VECTORS; that sample is fully checked and counted.
REQ-024 DONE->RUN on start=1, with the same clearing as REQ-019.
REQ-025 start while in RUN SHALL be ignored.
REQ-026 in_valid while in IDLE or DONE SHALL be ignored; no output changes.
REQ-027 start and in_valid in the same IDLE/DONE cycle: start wins, and the sample is not counted.
REQ-028 pass SHALL be 1 only if done=1, err_count==0 and coverage==8'hFF when NUM_VECTORS>=8; for NUM_VECTORS<8 the coverage term is omitted.
REQ-029 All outputs SHALL be registered; a sample at edge N is reflected in outputs after edge N, and done rises after the edge accepting the final sample.
REQ-030 A sample with any X/Z on a/b/cin/s/c SHALL count as a mismatch.
REQ-031 Duplicate {a,b,cin} codes SHALL be counted again and re-set the same coverage bit.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, busy=0, done=0, pass=0, err_count=0, coverage=0, fail_valid=0 and fail_vec=0, independent of clk.
REQ-033 rst asserted mid-RUN SHALL abort the run with no partial verdict; after release, a new start is required.
REQ-034 Release of rst SHALL take effect at the first clk edge with rst=0.

Verification
REQ-035 Exhaustive correct run: start, then 8 valid samples 000..111 with correct s/c -> done=1, pass=1, err_count=0, coverage=8'hFF, fail_valid=0.
REQ-036 Single fault: as REQ-035, but the sample a=1,b=1,cin=0 reports s=1,c=1 -> err_count=1, fail_vec=5'b11011, fail_valid=1, pass=0.
REQ-037 Incomplete coverage: 8 correct samples with 3'b000 repeated in place of 3'b111 -> coverage=8'h7F, pass=0, err_count=0.
REQ-038 Saturation: 20 all-wrong samples with NUM_VECTORS=20 -> err_count=15, and fail_vec holds the first sample.
REQ-039 Async reset mid-run: rst pulsed between clk edges after 3 samples -> all outputs reach reset values before the next edge; in_valid then ignored until start.
REQ-040 Gaps and restart: in_valid toggling 1/0 over 16 cycles (8 samples) -> done after the 8th accepted sample; start in DONE clears outputs and re-enters RUN; start during RUN has no effect.
